tlb_walker: RTL
===============

Name: tlb_walker

Overview:
- Parametrised successor to the core's fixed-size translation buffer.
- Fully associative, N_ENTRIES deep, with combinational lookup.
- A miss runs a modelled page-table walk: a multi-cycle FSM with an abort rule and a fill. Physical page = virtual page + PPN_OFFSET.
- Adds the asynchronous reset, flush, busy/stall signalling, round-robin replacement once the TLB is full, and a page-0 fault that is not gated by hit.
- Sits between the fetch/mem-stage address path and the caches.

Parameters:
- N_ENTRIES, 8: number of entries; a power of 2, at least 2.
- WIDTH, 20: virtual and physical page number width.
- WALK_DELAY, 3: walk latency in cycles; at least 1.
- PPN_OFFSET, 1: constant added to the VPN to form the PPN, modulo 2^WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- valid  in  1  translation request present.
- virtual_page  in  WIDTH  requested VPN.
- flush  in  1  invalidate all entries and abort any walk.
- physical_page_out  out  WIDTH  translated PPN; valid only when hit=1.
- hit  out  1  combinational match on a valid entry.
- exception  out  1  page fault.
- busy  out  1  walk in progress; requester must stall.

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low.
- Reset (reset_n=0, asynchronous):
  - all entry valid bits = 0, tags and PPNs = 0;
  - state = IDLE, counter = 0, round-robin pointer = 0, latched VPN = 0;
  - outputs: hit=0, exception=0, busy=0, physical_page_out=0.
- Lookup (combinational, every cycle, any state):
  - hit = valid && virtual_page != 0 && some valid entry's tag == virtual_page;
  - physical_page_out = that entry's PPN, else 0.
  - Duplicate tags cannot arise, because the fill re-checks the tag.
- Exception: exception = valid && virtual_page == 0. Page 0 never hits, never walks, never fills.
- FSM states: IDLE, WALK, FILL. busy = (state != IDLE).
- IDLE:
  - if valid && !hit && !exception && !flush: latch VPN, counter = WALK_DELAY-1, go to WALK;
  - otherwise stay.
- WALK, each edge:
  - abort to IDLE, no fill, if !valid || virtual_page != latched VPN || flush;
  - else if counter == 0, go to FILL;
  - else decrement counter.
- FILL, at the end of the cycle:
  - flush has priority: if flush, go to IDLE with no write;
  - else if the latched VPN is already present (tag check), go to IDLE with no write;
  - else write tag = latched VPN, PPN = latched VPN + PPN_OFFSET (truncated to WIDTH), valid = 1, and go to IDLE.
  - The FILL write does not require valid.
- Victim selection:
  - lowest-index invalid entry if any exists;
  - otherwise the entry at the round-robin pointer, which then increments and wraps N_ENTRIES-1 to 0;
  - the pointer only advances on a replacing fill.
- Latency: miss presented in cycle 0 → WALK in cycles 1..WALK_DELAY → FILL in cycle WALK_DELAY+1 → hit=1 in cycle WALK_DELAY+2, provided valid and the VPN are held throughout.
- Flush:
  - in any state, at the edge: all valid bits = 0, pointer = 0, state = IDLE;
  - hit in the flush cycle is still the pre-flush combinational value;
  - the cycle after a flush, no request can start a walk until flush is deasserted.
- Reset mid-walk: the walk is lost; no partial fill.

Decomposition:
- Package tlb_pkg:
  - state enum tlb_state_t {IDLE, WALK, FILL};
  - default-parameter localparams;
  - IDX_W = $clog2(N_ENTRIES);
  - CNT_W = $clog2(WALK_DELAY+1).
- Sub-module tlb_victim_sel:
  - inputs: valid vector, replacing-fill enable, flush;
  - holds the round-robin pointer;
  - output: victim index.
- Main module: tag/PPN arrays, match logic, FSM, walk counter.

Test Plan:
- Reset, then valid=1, VPN=0x00005 held, WALK_DELAY=3 → busy=1 in cycles 1–4; hit=1 with PPN 0x00006 in cycle 5; no duplicate entry if the VPN is held longer.
- VPN=0 with valid=1 → exception=1, hit=0, busy stays 0, no entry written.
- valid dropped in cycle 2 of a walk, then VPN 0x00005 re-presented → first walk aborts without a fill; the second miss takes the full WALK_DELAY+2 cycles.
- Fill 8 distinct VPNs 1–8, then VPN 9 → entry 0 replaced (VPN 1 now misses); then VPN 10 → entry 1 replaced; pointer wraps after entry 7.
- flush asserted during FILL of VPN 0x0000A → no write; all prior hits now miss; pointer = 0; the next fill goes to entry 0.
- VPN=0xFFFFF with PPN_OFFSET=1 → PPN 0x00000 (wrap), hit=1, exception=0.

Source files
------------

// File: rtl/tlb_pkg.sv
// Shared types and default sizing for the translation buffer and its page-table walker.
package tlb_pkg;

   typedef enum logic [1:0] {IDLE, WALK, FILL} tlb_state_t;

   localparam int DEF_N_ENTRIES  = 8;
   localparam int DEF_WIDTH      = 20;
   localparam int DEF_WALK_DELAY = 3;
   localparam int DEF_PPN_OFFSET = 1;

   localparam int IDX_W = $clog2(DEF_N_ENTRIES);
   localparam int CNT_W = $clog2(DEF_WALK_DELAY + 1);

endpackage

// File: rtl/tlb_victim_sel.sv
// Replacement choice: lowest-index invalid entry, else a round-robin pointer.
// Victim index is combinational; the pointer moves only on a replacing fill and clears on flush.
// No backpressure: it follows the fill strobe it is given.
module tlb_victim_sel #(
   parameter int N_ENTRIES = 8,
   parameter int IDX_W     = 3
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [N_ENTRIES-1:0] entry_valid,
   input  logic                 fill_en,
   input  logic                 flush,
   output logic [IDX_W-1:0]     victim
);

   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] free_idx;
   logic             any_free;

   // Scan downwards so the lowest free index is the one left standing.
   always_comb begin
      any_free = 1'b0;
      free_idx = '0;
      for (int i = N_ENTRIES - 1; i >= 0; i--) begin
         if (!entry_valid[i]) begin
            any_free = 1'b1;
            free_idx = IDX_W'(i);
         end
      end
   end

   assign victim = any_free ? free_idx : ptr;

   // N_ENTRIES is a power of two, so the natural wrap of ptr is the round-robin wrap.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr <= '0;
      end else if (flush) begin
         ptr <= '0;
      end else if (fill_en && !any_free) begin
         ptr <= ptr + IDX_W'(1);
      end
   end

endmodule

// File: rtl/tlb_walker.sv
// Fully associative TLB with combinational lookup and a modelled page-table walk on miss.
// Latency: hit same cycle; miss fills after WALK_DELAY+1 cycles, so the hit shows in cycle WALK_DELAY+2.
// Backpressure: busy is high while walking; the requester holds valid and the VPN, or the walk aborts.
module tlb_walker
   import tlb_pkg::*;
#(
   parameter int N_ENTRIES  = DEF_N_ENTRIES,
   parameter int WIDTH      = DEF_WIDTH,
   parameter int WALK_DELAY = DEF_WALK_DELAY,
   parameter int PPN_OFFSET = DEF_PPN_OFFSET
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             valid,
   input  logic [WIDTH-1:0] virtual_page,
   input  logic             flush,
   output logic [WIDTH-1:0] physical_page_out,
   output logic             hit,
   output logic             exception,
   output logic             busy
);

   localparam int IDX_BITS = $clog2(N_ENTRIES);
   localparam int CNT_BITS = $clog2(WALK_DELAY + 1);

   tlb_state_t           state, state_nxt;
   logic [CNT_BITS-1:0]  cnt, cnt_nxt;
   logic [WIDTH-1:0]     lat_vpn;
   logic [N_ENTRIES-1:0] ent_vld;
   logic [WIDTH-1:0]     ent_tag [N_ENTRIES];
   logic [WIDTH-1:0]     ent_ppn [N_ENTRIES];
   logic [N_ENTRIES-1:0] match, lat_match;
   logic [IDX_BITS-1:0]  victim;
   logic                 fill_en, walk_start;

   always_comb begin
      match             = '0;
      lat_match         = '0;
      physical_page_out = '0;
      for (int i = 0; i < N_ENTRIES; i++) begin
         match[i]     = ent_vld[i] && (ent_tag[i] == virtual_page);
         lat_match[i] = ent_vld[i] && (ent_tag[i] == lat_vpn);
      end
      hit = valid && (virtual_page != '0) && (|match);
      // Tags are unique, so OR-ing the matching PPNs selects exactly one.
      for (int i = 0; i < N_ENTRIES; i++) begin
         if (hit && match[i]) physical_page_out = physical_page_out | ent_ppn[i];
      end
   end

   assign exception  = valid && (virtual_page == '0);
   assign busy       = (state != IDLE);
   assign walk_start = (state == IDLE) && valid && !hit && !exception && !flush;
   // Re-checking the tag at fill time is what keeps duplicate entries out.
   assign fill_en    = (state == FILL) && !flush && !(|lat_match);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (walk_start) begin
               state_nxt = WALK;
               cnt_nxt   = CNT_BITS'(WALK_DELAY - 1);
            end
         end
         WALK: begin
            if (!valid || (virtual_page != lat_vpn) || flush) state_nxt = IDLE;
            else if (cnt == '0)                               state_nxt = FILL;
            else                                              cnt_nxt   = cnt - CNT_BITS'(1);
         end
         FILL:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         cnt     <= '0;
         lat_vpn <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (walk_start) lat_vpn <= virtual_page;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ent_vld <= '0;
         for (int i = 0; i < N_ENTRIES; i++) begin
            ent_tag[i] <= '0;
            ent_ppn[i] <= '0;
         end
      end else if (flush) begin
         ent_vld <= '0;
      end else if (fill_en) begin
         ent_vld[victim] <= 1'b1;
         ent_tag[victim] <= lat_vpn;
         ent_ppn[victim] <= lat_vpn + WIDTH'(PPN_OFFSET);
      end
   end

   tlb_victim_sel #(
      .N_ENTRIES (N_ENTRIES),
      .IDX_W     (IDX_BITS)
   ) u_victim_sel (
      .clk         (clk),
      .reset_n     (reset_n),
      .entry_valid (ent_vld),
      .fill_en     (fill_en),
      .flush       (flush),
      .victim      (victim)
   );

endmodule
